hash_core_scheduler: RTL

HASH_CORE_SCHEDULER -- requirements
Module: hash_core_scheduler

---
 rtl/hash_sched_pkg.sv | 20 ++
 rtl/hash_core_scheduler_rr_arbiter.sv | 30 +++
 rtl/hash_core_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hash_sched_pkg.sv
// Shared types for the hash core scheduler: FSM state, length type, defaults.
// Latency: n/a (types only).
// Backpressure: n/a.
package hash_sched_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_WAIT   = 2'd2,
      ST_FINISH = 2'd3
   } sched_state_e;

   typedef logic [63:0] len_t;

   localparam int N_REQ_DEF       = 4;
   localparam int TIMEOUT_CYC_DEF = 64;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/hash_core_scheduler_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; caller decides when the result is used.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          vld
);
   logic [IW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      j   = '0;
      for (int i = 0; i < N; i++) begin
         j = IW'((int'(ptr) + i) % N);
         if (!vld && req[j]) begin
            vld    = 1'b1;
            idx    = j;
            gnt[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hash_core_scheduler.sv
// Shares one hash core among N_REQ requesters: grant, stream bytes, await digest.
// Latency: grant 1 cycle after req; bytes reach M 1 cycle after acceptance.
// Backpressure: byte_ready only to the winner; stalls become zero bytes plus err.
module hash_core_scheduler
   import hash_sched_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*64-1:0] req_len,
   input  logic [N_REQ-1:0]    byte_valid,
   input  logic [N_REQ*8-1:0]  byte_data,
   output logic [N_REQ-1:0]    byte_ready,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic [N_REQ-1:0]    err,
   output logic [31:0]         digest_out,
   output logic                busy,
   output logic                M_valid,
   output logic [7:0]          M,
   output logic [63:0]         input_lenght,
   input  logic                hash_ready,
   input  logic [31:0]         digest
);
   localparam int IW = idx_w(N_REQ);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   sched_state_e  state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] cur;
   len_t          issued;
   logic          gap;
   logic [CW-1:0] wait_cnt;

   logic [N_REQ-1:0] arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_vld;
   len_t             win_len;
   logic [7:0]       cur_byte;
   logic             cur_valid;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .vld (arb_vld)
   );

   assign win_len   = req_len[64*int'(arb_idx) +: 64];
   assign cur_byte  = byte_data[8*int'(cur) +: 8];
   assign cur_valid = byte_valid[cur];

   assign byte_ready = (state == ST_STREAM && issued < input_lenght) ? gnt : '0;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         cur          <= '0;
         gnt          <= '0;
         done         <= '0;
         err          <= '0;
         digest_out   <= '0;
         M_valid      <= 1'b0;
         M            <= '0;
         input_lenght <= '0;
         issued       <= '0;
         gap          <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= '0;
               err  <= '0;
               if (arb_vld) begin
                  ptr <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
                  if (win_len != '0) begin
                     state        <= ST_STREAM;
                     gnt          <= arb_gnt;
                     cur          <= arb_idx;
                     input_lenght <= win_len;
                     issued       <= '0;
                     gap          <= 1'b0;
                     wait_cnt     <= '0;
                  end else begin
                     err <= arb_gnt;
                  end
               end
            end
            ST_STREAM: begin
               // One byte per cycle regardless of byte_valid so M_valid stays contiguous.
               M_valid <= 1'b1;
               if (gap || !cur_valid) begin
                  M   <= '0;
                  gap <= 1'b1;
               end else begin
                  M <= cur_byte;
               end
               issued <= issued + 64'd1;
               if (issued + 64'd1 == input_lenght) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               M_valid <= 1'b0;
               M       <= '0;
               if (hash_ready) begin
                  state <= ST_FINISH;
                  if (gap) begin
                     err <= gnt;
                  end else begin
                     done       <= gnt;
                     digest_out <= digest;
                  end
               end else if (!M_valid) begin
                  if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                     state <= ST_FINISH;
                     err   <= gnt;
                  end else begin
                     wait_cnt <= wait_cnt + CW'(1);
                  end
               end
            end
            ST_FINISH: begin
               done     <= '0;
               err      <= '0;
               gnt      <= '0;
               wait_cnt <= '0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
